// File: rtl/arp_responder_host_learn.sv
// ARP responder: answers ARP requests for LOCAL_IP on the MAC Tx stream and
// learns the host PC MAC from requests whose sender IP is HOST_IP.
//
// state      | meaning
// RX_HDR     | comparing header bytes on the fly, capturing SHA/SPA
// RX_DISCARD | mismatch seen, dropping bytes until tlast
// TX_IDLE    | no reply in flight
// TX_SEND    | streaming the 60-byte reply
module arp_responder_host_learn #(
    parameter logic [47:0] LOCAL_MAC = 48'h060708090a0b,
    parameter logic [31:0] LOCAL_IP  = {8'd10, 8'd2, 8'd2, 8'd2},
    parameter logic [31:0] HOST_IP   = {8'd10, 8'd2, 8'd2, 8'd1}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    input  logic        tx_tready,
    output logic [47:0] host_mac,
    output logic        host_mac_valid,
    output logic [15:0] reply_drop_cnt
);
    typedef enum logic {RX_HDR, RX_DISCARD} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    localparam logic [5:0] LAST_TX_IDX     = 6'd59;
    localparam logic [5:0] MIN_LAST_RX_IDX = 6'd41;

    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [5:0] i);
        case (i)
            6'd0:    mac_byte = m[47:40];
            6'd1:    mac_byte = m[39:32];
            6'd2:    mac_byte = m[31:24];
            6'd3:    mac_byte = m[23:16];
            6'd4:    mac_byte = m[15:8];
            6'd5:    mac_byte = m[7:0];
            default: mac_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [5:0] i);
        case (i)
            6'd0:    ip_byte = a[31:24];
            6'd1:    ip_byte = a[23:16];
            6'd2:    ip_byte = a[15:8];
            6'd3:    ip_byte = a[7:0];
            default: ip_byte = 8'h00;
        endcase
    endfunction

    // Ethertype + fixed ARP header, bytes 12..21; only the opcode differs.
    function automatic logic [7:0] arp_fixed_byte(input logic [5:0] i, input logic is_reply);
        case (i)
            6'd12:   arp_fixed_byte = 8'h08;
            6'd13:   arp_fixed_byte = 8'h06;
            6'd14:   arp_fixed_byte = 8'h00;
            6'd15:   arp_fixed_byte = 8'h01;
            6'd16:   arp_fixed_byte = 8'h08;
            6'd17:   arp_fixed_byte = 8'h00;
            6'd18:   arp_fixed_byte = 8'h06;
            6'd19:   arp_fixed_byte = 8'h04;
            6'd20:   arp_fixed_byte = 8'h00;
            6'd21:   arp_fixed_byte = is_reply ? 8'h02 : 8'h01;
            default: arp_fixed_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] reply_byte(input logic [5:0] i, input logic [47:0] sha,
                                              input logic [31:0] spa);
        logic [7:0] b;
        b = 8'h00;
        if (i < 6'd6)       b = mac_byte(sha, i);
        else if (i < 6'd12) b = mac_byte(LOCAL_MAC, i - 6'd6);
        else if (i < 6'd22) b = arp_fixed_byte(i, 1'b1);
        else if (i < 6'd28) b = mac_byte(LOCAL_MAC, i - 6'd22);
        else if (i < 6'd32) b = ip_byte(LOCAL_IP, i - 6'd28);
        else if (i < 6'd38) b = mac_byte(sha, i - 6'd32);
        else if (i < 6'd42) b = ip_byte(spa, i - 6'd38);
        return b;
    endfunction

    rx_state_t   rx_state, rx_next;
    tx_state_t   tx_state, tx_next;
    logic [5:0]  rx_idx;
    logic [5:0]  tx_idx;
    logic [5:0]  tx_idx_inc;
    logic        bc_ok, uc_ok, bc_nxt, uc_nxt;
    logic        mism;
    logic        frame_ok;
    logic [47:0] sha_shadow, rep_sha;
    logic [31:0] spa_shadow, rep_spa;
    logic        tx_hs, tx_done, tx_free, tx_start;

    assign rx_tready = 1'b1;

    always_comb begin
        bc_nxt = bc_ok;
        uc_nxt = uc_ok;
        mism   = 1'b0;
        if (rx_idx < 6'd6) begin
            bc_nxt = bc_ok & (rx_tdata == 8'hff);
            uc_nxt = uc_ok & (rx_tdata == mac_byte(LOCAL_MAC, rx_idx));
            mism   = !(bc_nxt | uc_nxt);
        end else if (rx_idx >= 6'd12 && rx_idx <= 6'd21) begin
            mism = (rx_tdata != arp_fixed_byte(rx_idx, 1'b0));
        end else if (rx_idx >= 6'd38 && rx_idx <= MIN_LAST_RX_IDX) begin
            mism = (rx_tdata != ip_byte(LOCAL_IP, rx_idx - 6'd38));
        end
    end

    assign frame_ok = rx_tvalid & rx_tlast & (rx_state == RX_HDR) & !mism
                      & (rx_idx >= MIN_LAST_RX_IDX) & !rx_tuser;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_HDR;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (rx_tvalid) begin
            if (rx_tlast)                         rx_next = RX_HDR;
            else if (rx_state == RX_HDR && mism)  rx_next = RX_DISCARD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_idx     <= 6'd0;
            bc_ok      <= 1'b1;
            uc_ok      <= 1'b1;
            sha_shadow <= 48'h0;
            spa_shadow <= 32'h0;
        end else if (rx_tvalid) begin
            if (rx_tlast) begin
                rx_idx <= 6'd0;
                bc_ok  <= 1'b1;
                uc_ok  <= 1'b1;
            end else begin
                if (rx_idx != 6'd63) rx_idx <= rx_idx + 6'd1;
                bc_ok <= bc_nxt;
                uc_ok <= uc_nxt;
            end
            if (rx_state == RX_HDR) begin
                if (rx_idx >= 6'd22 && rx_idx <= 6'd27) sha_shadow <= {sha_shadow[39:0], rx_tdata};
                if (rx_idx >= 6'd28 && rx_idx <= 6'd31) spa_shadow <= {spa_shadow[23:0], rx_tdata};
            end
        end
    end

    // A request landing on the final reply handshake is taken rather than dropped.
    assign tx_hs      = tx_tvalid & tx_tready;
    assign tx_done    = tx_hs & (tx_idx == LAST_TX_IDX);
    assign tx_free    = (tx_state == TX_IDLE) | tx_done;
    assign tx_start   = frame_ok & tx_free;
    assign tx_idx_inc = tx_idx + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_start) tx_next = TX_SEND;
            TX_SEND: if (tx_done)  tx_next = tx_start ? TX_SEND : TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_idx    <= 6'd0;
            tx_tdata  <= 8'h00;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            rep_sha   <= 48'h0;
            rep_spa   <= 32'h0;
        end else if (tx_start) begin
            rep_sha   <= sha_shadow;
            rep_spa   <= spa_shadow;
            tx_idx    <= 6'd0;
            tx_tdata  <= reply_byte(6'd0, sha_shadow, spa_shadow);
            tx_tvalid <= 1'b1;
            tx_tlast  <= 1'b0;
        end else if (tx_done) begin
            tx_idx    <= 6'd0;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
        end else if (tx_hs) begin
            tx_idx    <= tx_idx_inc;
            tx_tdata  <= reply_byte(tx_idx_inc, rep_sha, rep_spa);
            tx_tlast  <= (tx_idx_inc == LAST_TX_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_mac       <= 48'h0;
            host_mac_valid <= 1'b0;
            reply_drop_cnt <= 16'h0;
        end else if (frame_ok) begin
            if (spa_shadow == HOST_IP) begin
                host_mac       <= sha_shadow;
                host_mac_valid <= 1'b1;
            end
            if (!tx_free && reply_drop_cnt != 16'hffff)
                reply_drop_cnt <= reply_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_arp_responder_host_learn.sv
// Scoreboard bench for arp_responder_host_learn: expected reply bytes are queued
// when a request is driven and popped on each Tx handshake.
module tb_arp_responder_host_learn;
    localparam logic [47:0] LOCAL_MAC = 48'h060708090a0b;
    localparam logic [31:0] LOCAL_IP  = 32'h0a020202;
    localparam logic [31:0] HOST_IP   = 32'h0a020201;
    localparam logic [47:0] SHA1      = 48'h001122334455;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_tlast, rx_tuser;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid, tx_tlast, tx_tready;
    logic [47:0] host_mac;
    logic        host_mac_valid;
    logic [15:0] reply_drop_cnt;

    logic tready_hold, tready_rand, rand_bit;
    assign tx_tready = tready_rand ? rand_bit : tready_hold;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    arp_responder_host_learn dut (
        .clk(clk), .rst_n(rst_n),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .host_mac(host_mac), .host_mac_valid(host_mac_valid), .reply_drop_cnt(reply_drop_cnt)
    );

    logic [8:0] exp_q[$];
    logic [7:0] frm[$];
    int n_cmp = 0, n_bad = 0;
    int n_pop = 0, n_replies = 0, n_tv = 0;

    task automatic build_req(input bit bcast, input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input logic [15:0] etype, input int len);
        logic [47:0] dst;
        logic [63:0] arp;
        frm.delete();
        dst = bcast ? 48'hffffffffffff : LOCAL_MAC;
        arp = 64'h0001_0800_0604_0001;
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        for (int i = 0; i < 8; i++) frm.push_back(arp[63-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) frm.push_back(spa[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'h00);
        for (int i = 0; i < 4; i++) frm.push_back(tpa[31-8*i -: 8]);
        while (frm.size() < len) frm.push_back(8'h00);
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    task automatic push_reply(input logic [47:0] sha, input logic [31:0] spa);
        logic [7:0]  b[$];
        logic [79:0] hdr;
        hdr = 80'h0806_0001_0800_0604_0002;
        for (int i = 0; i < 6; i++)  b.push_back(sha[47-8*i -: 8]);
        for (int i = 0; i < 6; i++)  b.push_back(LOCAL_MAC[47-8*i -: 8]);
        for (int i = 0; i < 10; i++) b.push_back(hdr[79-8*i -: 8]);
        for (int i = 0; i < 6; i++)  b.push_back(LOCAL_MAC[47-8*i -: 8]);
        for (int i = 0; i < 4; i++)  b.push_back(LOCAL_IP[31-8*i -: 8]);
        for (int i = 0; i < 6; i++)  b.push_back(sha[47-8*i -: 8]);
        for (int i = 0; i < 4; i++)  b.push_back(spa[31-8*i -: 8]);
        while (b.size() < 60) b.push_back(8'h00);
        for (int i = 0; i < 60; i++) exp_q.push_back({(i == 59), b[i]});
    endtask

    task automatic send_frame(input logic tuser_last);
        for (int i = 0; i < frm.size(); i++) begin
            rx_tdata  = frm[i];
            rx_tvalid = 1'b1;
            rx_tlast  = (i == frm.size() - 1);
            rx_tuser  = rx_tlast & tuser_last;
            @(posedge clk); #1;
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
        rx_tdata  = 8'h00;
    endtask

    // Watches Tx at the falling edge; a valid&ready seen here completes at the next rise.
    task automatic run_tx(input int max_cyc, input bit until_empty, input string tag);
        int c;
        bit done, stalled;
        logic [8:0] held, e;
        c = 0; done = 0; stalled = 0; held = '0;
        while (!done && c < max_cyc) begin
            @(negedge clk);
            c++;
            if (tx_tvalid) n_tv++;
            if (tx_tvalid && stalled) begin
                n_cmp++;
                if ({tx_tlast, tx_tdata} !== held) begin
                    n_bad++;
                    $display("FAIL %s hold_stable: got %h required %h", tag, {tx_tlast, tx_tdata}, held);
                end
            end
            stalled = tx_tvalid && !tx_tready;
            held = {tx_tlast, tx_tdata};
            if (tx_tvalid && tx_tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s unexpected_tx: got byte %h, required no reply byte", tag, tx_tdata);
                end else begin
                    e = exp_q.pop_front();
                    n_pop++;
                    if ({tx_tlast, tx_tdata} !== e) begin
                        n_bad++;
                        $display("FAIL %s reply_byte %0d: got last/data %h required %h",
                                 tag, 59 - exp_q.size() % 60, {tx_tlast, tx_tdata}, e);
                    end
                end
                if (tx_tlast) n_replies++;
            end
            if (until_empty && exp_q.size() == 0 && !tx_tvalid) done = 1;
        end
        if (until_empty && !done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: %0d bytes still expected, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_tdata = 8'h00; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
        tready_hold = 1'b1; tready_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({rx_tready, tx_tvalid, tx_tlast, tx_tdata, host_mac_valid, host_mac, reply_drop_cnt}
            !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 48'h0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b tv=%b tl=%b td=%h hv=%b hm=%h cnt=%h, required rdy=1 rest 0",
                     rx_tready, tx_tvalid, tx_tlast, tx_tdata, host_mac_valid, host_mac, reply_drop_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rx_tready, tx_tvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL after_reset: got rdy=%b tv=%b required rdy=1 tv=0", rx_tready, tx_tvalid);
        end
    endtask

    task automatic test_reject();
        int tv0;
        tv0 = n_tv;
        build_req(1, SHA1, HOST_IP, 32'h0a020209, 16'h0806, 42);
        send_frame(0);
        run_tx(10, 0, "wrong_tpa");
        build_req(1, SHA1, HOST_IP, LOCAL_IP, 16'h0800, 42);
        send_frame(0);
        run_tx(10, 0, "wrong_etype");
        build_req(1, SHA1, HOST_IP, LOCAL_IP, 16'h0806, 41);
        send_frame(0);
        run_tx(10, 0, "short_frame");
        n_cmp++;
        if (n_tv !== tv0) begin
            n_bad++;
            $display("FAIL reject_no_tx: got %0d valid cycles required 0", n_tv - tv0);
        end
        n_cmp++;
        if (host_mac_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reject_no_learn: got host_mac_valid=%b required 0", host_mac_valid);
        end
    endtask

    task automatic test_broadcast();
        int r0;
        r0 = n_replies;
        push_reply(SHA1, HOST_IP);
        build_req(1, SHA1, HOST_IP, LOCAL_IP, 16'h0806, 42);
        send_frame(0);
        n_cmp++;
        if ({tx_tvalid, host_mac_valid, host_mac} !== {1'b1, 1'b1, SHA1}) begin
            n_bad++;
            $display("FAIL bcast_first_cycle: got tv=%b hv=%b hm=%h required tv=1 hv=1 hm=%h",
                     tx_tvalid, host_mac_valid, host_mac, SHA1);
        end
        run_tx(200, 1, "bcast");
        n_cmp++;
        if (n_replies !== r0 + 1) begin
            n_bad++;
            $display("FAIL bcast_reply_count: got %0d required 1", n_replies - r0);
        end
    endtask

    task automatic test_non_host();
        int r0;
        r0 = n_replies;
        push_reply(48'haabbccddeeff, 32'h0a020207);
        build_req(1, 48'haabbccddeeff, 32'h0a020207, LOCAL_IP, 16'h0806, 42);
        send_frame(0);
        run_tx(200, 1, "non_host");
        n_cmp++;
        if ({host_mac_valid, host_mac} !== {1'b1, SHA1}) begin
            n_bad++;
            $display("FAIL non_host_keep_mac: got hv=%b hm=%h required hv=1 hm=%h", host_mac_valid, host_mac, SHA1);
        end
        n_cmp++;
        if (n_replies !== r0 + 1) begin
            n_bad++;
            $display("FAIL non_host_reply_count: got %0d required 1", n_replies - r0);
        end
    endtask

    task automatic test_backpressure();
        int r0, tv0;
        r0 = n_replies;
        push_reply(SHA1, HOST_IP);
        build_req(0, SHA1, HOST_IP, LOCAL_IP, 16'h0806, 60);
        send_frame(0);
        tready_rand = 1'b1;
        run_tx(1000, 1, "backpressure");
        tready_rand = 1'b0;
        n_cmp++;
        if (n_replies !== r0 + 1) begin
            n_bad++;
            $display("FAIL backpressure_reply_count: got %0d required 1", n_replies - r0);
        end
        tv0 = n_tv;
        build_req(0, 48'h112233445566, HOST_IP, LOCAL_IP, 16'h0806, 60);
        send_frame(1);
        run_tx(20, 0, "tuser_err");
        n_cmp++;
        if (n_tv !== tv0 || host_mac !== SHA1) begin
            n_bad++;
            $display("FAIL tuser_err_drop: got tv_cycles=%0d hm=%h required 0 and %h", n_tv - tv0, host_mac, SHA1);
        end
    endtask

    task automatic test_busy_drop();
        int r0, base, c;
        r0 = n_replies;
        push_reply(48'h0a0b0c0d0e0f, HOST_IP);
        build_req(1, 48'h0a0b0c0d0e0f, HOST_IP, LOCAL_IP, 16'h0806, 42);
        send_frame(0);
        base = n_pop;
        fork
            run_tx(2000, 1, "busy_reply");
            begin
                c = 0;
                while (n_pop - base < 10 && c < 200) begin
                    @(posedge clk); #1;
                    c++;
                end
                tready_hold = 1'b0;
                build_req(1, 48'h102030405060, HOST_IP, LOCAL_IP, 16'h0806, 42);
                send_frame(0);
                repeat (2) @(posedge clk);
                #1;
                n_cmp++;
                if (reply_drop_cnt !== 16'd1) begin
                    n_bad++;
                    $display("FAIL busy_drop_cnt: got %0d required 1", reply_drop_cnt);
                end
                n_cmp++;
                if (host_mac !== 48'h102030405060) begin
                    n_bad++;
                    $display("FAIL busy_learn: got %h required 102030405060", host_mac);
                end
                repeat (5) @(posedge clk);
                #1;
                tready_hold = 1'b1;
            end
        join
        run_tx(80, 0, "busy_tail");
        n_cmp++;
        if (n_replies !== r0 + 1) begin
            n_bad++;
            $display("FAIL busy_reply_count: got %0d required 1", n_replies - r0);
        end
    endtask

    task automatic test_reset_mid_reply();
        int r0, base, c;
        push_reply(48'h223344556677, HOST_IP);
        build_req(1, 48'h223344556677, HOST_IP, LOCAL_IP, 16'h0806, 42);
        send_frame(0);
        base = n_pop;
        fork
            run_tx(500, 1, "abandoned_reply");
            begin
                c = 0;
                while (n_pop - base < 30 && c < 200) begin
                    @(posedge clk); #1;
                    c++;
                end
                n_cmp++;
                if (n_pop - base < 30) begin
                    n_bad++;
                    $display("FAIL reach_byte30: got %0d bytes required 30", n_pop - base);
                end
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({tx_tvalid, host_mac_valid} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL async_reset: got tv=%b hv=%b required 0 0", tx_tvalid, host_mac_valid);
                end
                exp_q.delete();
            end
        join
        n_cmp++;
        if (reply_drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_drop_cnt: got %0d required 0", reply_drop_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r0 = n_replies;
        push_reply(48'h8899aabbccdd, HOST_IP);
        build_req(0, 48'h8899aabbccdd, HOST_IP, LOCAL_IP, 16'h0806, 42);
        send_frame(0);
        run_tx(200, 1, "post_reset");
        n_cmp++;
        if (n_replies !== r0 + 1 || {host_mac_valid, host_mac} !== {1'b1, 48'h8899aabbccdd}) begin
            n_bad++;
            $display("FAIL post_reset_reply: got replies=%0d hv=%b hm=%h required 1 1 8899aabbccdd",
                     n_replies - r0, host_mac_valid, host_mac);
        end
    endtask

    initial begin
        test_reset();
        test_reject();
        test_broadcast();
        test_non_host();
        test_backpressure();
        test_busy_drop();
        test_reset_mid_reply();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
